// File: rtl/dma_ctrl_pkg.sv
// Shared definitions for the DMA controller: FSM state encodings, host
// register offsets and CTRL register bit positions.
package dma_ctrl_pkg;

  // 3-bit DMA FSM state encoding.
  typedef enum logic [2:0] {
    DMA_IDLE = 3'd0,
    DMA_REQ  = 3'd1,
    DMA_RD   = 3'd2,
    DMA_WR   = 3'd3,
    DMA_REL  = 3'd4,
    DMA_DONE = 3'd5
  } dma_state_e;

  // Host register offsets on cfg_addr.
  localparam logic [1:0] REG_SRC  = 2'd0;
  localparam logic [1:0] REG_DST  = 2'd1;
  localparam logic [1:0] REG_CNT  = 2'd2;
  localparam logic [1:0] REG_CTRL = 2'd3;

  // CTRL bit positions (write: start / clear-done, read: busy / done).
  localparam int CTRL_START = 0;
  localparam int CTRL_DONE  = 1;

endpackage

// File: rtl/dma_regs.sv
// DMA host register file.
// Holds SRC/DST/CNT and the sticky done flag, decodes the start command and
// provides the combinational readback mux.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   cfg_we_i/addr_i/wdata_i  host write port
//   cfg_rdata_o        readback of the register selected by cfg_addr_i
//   busy_i             transfer in progress (locks SRC/DST/CNT and start)
//   advance_i          one word copied: SRC+1, DST+1, CNT-1
//   done_set_i         transfer finished: set done_sticky
//   src_o/dst_o/cnt_o  live register values
//   start_o            accepted start command (single cycle)
module dma_regs
  import dma_ctrl_pkg::*;
#(
  parameter int AW = 16,
  parameter int DW = 16,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cfg_we_i,
  input  logic [1:0]    cfg_addr_i,
  input  logic [DW-1:0] cfg_wdata_i,
  output logic [DW-1:0] cfg_rdata_o,
  input  logic          busy_i,
  input  logic          advance_i,
  input  logic          done_set_i,
  output logic [AW-1:0] src_o,
  output logic [AW-1:0] dst_o,
  output logic [CW-1:0] cnt_o,
  output logic          start_o
);

  logic [AW-1:0] src_q, src_d;
  logic [AW-1:0] dst_q, dst_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_sticky_q, done_sticky_d;
  logic          wr_ok;
  logic          ctrl_wr;

  // Only a done-clear gets through while a transfer is running.
  assign wr_ok   = cfg_we_i && !busy_i;
  assign ctrl_wr = cfg_we_i && (cfg_addr_i == REG_CTRL);
  assign start_o = wr_ok && (cfg_addr_i == REG_CTRL) && cfg_wdata_i[CTRL_START];

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    src_d         = src_q;
    dst_d         = dst_q;
    cnt_d         = cnt_q;
    done_sticky_d = done_sticky_q;

    if (advance_i) begin
      // Address arithmetic wraps naturally modulo 2^AW.
      src_d = src_q + AW'(1);
      dst_d = dst_q + AW'(1);
      cnt_d = cnt_q - CW'(1);
    end else if (wr_ok) begin
      case (cfg_addr_i)
        REG_SRC: src_d = cfg_wdata_i[AW-1:0];
        REG_DST: dst_d = cfg_wdata_i[AW-1:0];
        REG_CNT: cnt_d = cfg_wdata_i[CW-1:0];
        default: ;
      endcase
    end

    if (ctrl_wr && cfg_wdata_i[CTRL_DONE]) done_sticky_d = 1'b0;
    // A completing transfer wins over a simultaneous clear.
    if (done_set_i) done_sticky_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q         <= '0;
      dst_q         <= '0;
      cnt_q         <= '0;
      done_sticky_q <= 1'b0;
    end else begin
      // NOTE: sequential state is updated with non-blocking assignments so
      // every register samples the pre-edge values.
      src_q         <= src_d;
      dst_q         <= dst_d;
      cnt_q         <= cnt_d;
      done_sticky_q <= done_sticky_d;
    end
  end

  always_comb begin
    cfg_rdata_o = '0;
    case (cfg_addr_i)
      REG_SRC: cfg_rdata_o = DW'(src_q);
      REG_DST: cfg_rdata_o = DW'(dst_q);
      REG_CNT: cfg_rdata_o = DW'(cnt_q);
      default: begin
        cfg_rdata_o[CTRL_START] = busy_i;
        cfg_rdata_o[CTRL_DONE]  = done_sticky_q;
      end
    endcase
  end

  assign src_o = src_q;
  assign dst_o = dst_q;
  assign cnt_o = cnt_q;

endmodule

// File: rtl/dma_ctrl.sv
// DMA block-copy controller.
// Copies CNT words from SRC to DST over the shared system bus, one read beat
// followed by one write beat per word. Holds the bus for at most BURST words,
// then drops dma_breq for one cycle so the arbiter can rotate.
// Ports:
//   clk, reset                    clock, asynchronous active-low reset
//   cfg_we/addr/wdata, cfg_rdata  host register port (readback combinational)
//   dma_breq, dma_grant           arbiter handshake
//   bus_addr/rd/wr/wdata          bus master outputs, held until bus_ack
//   bus_rdata, bus_ack            bus slave response
//   dma_busy, dma_done            status: in progress / one-cycle completion
//   scan_in0, scan_en, scan_out0  scan hooks (output tied low, DFT stitches)
module dma_ctrl
  import dma_ctrl_pkg::*;
#(
  parameter int AW    = 16,
  parameter int DW    = 16,
  parameter int CW    = 8,
  parameter int BURST = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cfg_we,
  input  logic [1:0]    cfg_addr,
  input  logic [DW-1:0] cfg_wdata,
  output logic [DW-1:0] cfg_rdata,
  output logic          dma_breq,
  input  logic          dma_grant,
  output logic [AW-1:0] bus_addr,
  output logic          bus_rd,
  output logic          bus_wr,
  output logic [DW-1:0] bus_wdata,
  input  logic [DW-1:0] bus_rdata,
  input  logic          bus_ack,
  output logic          dma_busy,
  output logic          dma_done,
  input  logic          scan_in0,
  input  logic          scan_en,
  output logic          scan_out0
);

  localparam int BW = $clog2(BURST + 1);

  dma_state_e    state_q, state_d;
  logic [DW-1:0] data_q, data_d;
  logic [BW-1:0] beat_q, beat_d;

  logic [AW-1:0] src;
  logic [AW-1:0] dst;
  logic [CW-1:0] cnt;
  logic          start;
  logic          advance;

  logic          unused_scan;
  assign unused_scan = ^{scan_in0, scan_en};
  assign scan_out0   = 1'b0;

  assign dma_busy = (state_q != DMA_IDLE);

  dma_regs #(
    .AW(AW),
    .DW(DW),
    .CW(CW)
  ) u_regs (
    .clk        (clk),
    .rst_n      (reset),
    .cfg_we_i   (cfg_we),
    .cfg_addr_i (cfg_addr),
    .cfg_wdata_i(cfg_wdata),
    .cfg_rdata_o(cfg_rdata),
    .busy_i     (dma_busy),
    .advance_i  (advance),
    .done_set_i (dma_done),
    .src_o      (src),
    .dst_o      (dst),
    .cnt_o      (cnt),
    .start_o    (start)
  );

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    beat_d    = beat_q;
    advance   = 1'b0;
    dma_breq  = 1'b0;
    bus_rd    = 1'b0;
    bus_wr    = 1'b0;
    bus_addr  = '0;
    bus_wdata = '0;
    dma_done  = 1'b0;

    case (state_q)
      DMA_IDLE: begin
        beat_d = '0;
        if (start) state_d = (cnt == '0) ? DMA_DONE : DMA_REQ;
      end

      DMA_REQ: begin
        dma_breq = 1'b1;
        if (dma_grant) state_d = DMA_RD;
      end

      DMA_RD: begin
        dma_breq = 1'b1;
        bus_rd   = 1'b1;
        bus_addr = src;
        if (bus_ack) begin
          data_d  = bus_rdata;
          state_d = DMA_WR;
        end
      end

      DMA_WR: begin
        // The write finishes even if grant has dropped; grant only gates the
        // launch of the next read.
        dma_breq  = 1'b1;
        bus_wr    = 1'b1;
        bus_addr  = dst;
        bus_wdata = data_q;
        if (bus_ack) begin
          advance = 1'b1;
          beat_d  = beat_q + BW'(1);
          if (cnt == CW'(1))             state_d = DMA_DONE;
          else if (beat_q == BW'(BURST - 1)) state_d = DMA_REL;
          else if (dma_grant)            state_d = DMA_RD;
          else                           state_d = DMA_REQ;
        end
      end

      DMA_REL: begin
        // Grant is ignored here: the arbiter still shows the old grant for
        // one cycle after breq falls.
        beat_d  = '0;
        state_d = DMA_REQ;
      end

      DMA_DONE: begin
        dma_done = 1'b1;
        state_d  = DMA_IDLE;
      end

      default: state_d = DMA_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= DMA_IDLE;
      data_q  <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      beat_q  <= beat_d;
    end
  end

endmodule

// File: doc/dma_ctrl.md
Name: dma_ctrl

Overview:
DMA controller that copies a block of words from a source address to a destination address over the shared system bus. It sits directly upstream of the bus arbiter: it drives dma_breq and consumes dma_grant. A host (TDSP) programs it through a small register port. It holds the bus for at most BURST words, then releases it so the arbiter can rotate to the TDSP.

Parameters:
AW, 16, bus address width
DW, 16, bus and config data width (must be >= AW and >= CW)
CW, 8, word-count width
BURST, 4, max words moved per bus tenure (>=1)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-low reset (0 = reset)
cfg_we  in  1  register write strobe
cfg_addr  in  2  register select: 0 SRC, 1 DST, 2 CNT, 3 CTRL
cfg_wdata  in  DW  register write data
cfg_rdata  out  DW  register read data (combinational on cfg_addr)
dma_breq  out  1  bus request to arbiter
dma_grant  in  1  bus grant from arbiter
bus_addr  out  AW  bus address
bus_rd  out  1  read strobe, held until bus_ack
bus_wr  out  1  write strobe, held until bus_ack
bus_wdata  out  DW  write data
bus_rdata  in  DW  read data, valid with bus_ack
bus_ack  in  1  beat complete
dma_busy  out  1  transfer in progress
dma_done  out  1  one-cycle completion pulse
scan_in0  in  1  scan data in
scan_en  in  1  scan enable
scan_out0  out  1  scan data out (tie 0; stitched by DFT)

Behaviour:
- Reset (reset=0, async): FSM=IDLE; SRC/DST/CNT/data reg/beat counter=0; done_sticky=0. All outputs 0.
- Registers: SRC[AW-1:0], DST[AW-1:0], CNT[CW-1:0].
- CTRL write: bit0=start; bit1=1 clears done_sticky. CTRL read: bit0=busy, bit1=done_sticky, other bits 0.
- All cfg writes are ignored while busy, except a done_sticky clear.
- Reads of SRC/DST/CNT return live values (zero-extended to DW).
- FSM states: IDLE, REQ, RD, WR, REL, DONE. busy=1 in every state except IDLE.
- IDLE: on start with CNT!=0 -> REQ. On start with CNT==0 -> DONE (no bus activity).
- REQ: breq=1. When dma_grant=1 -> RD (beat counter cleared on entry from REL/IDLE).
- RD: breq=1, bus_rd=1, bus_addr=SRC. On bus_ack, latch bus_rdata -> WR.
- WR: breq=1, bus_wr=1, bus_addr=DST, bus_wdata=data reg. On bus_ack: SRC+=1, DST+=1, CNT-=1, beat+=1, then:
  - CNT==1 before decrement -> DONE
  - else beat+1==BURST -> REL
  - else dma_grant=1 -> RD
  - else -> REQ (breq held)
- REL: breq=0 for exactly one cycle; dma_grant is ignored, since the arbiter's grant lags by a cycle. Next state REQ.
- DONE: breq=0, dma_done=1 for one cycle, done_sticky set -> IDLE.
- bus_rd and bus_wr are never high together. Strobes and address are stable until ack. bus_ack outside RD/WR is ignored.
- A beat in flight completes even if dma_grant drops mid-beat. A new beat is launched only when grant=1.
- SRC/DST wrap modulo 2^AW (0xFFFF+1 -> 0x0000).
- Minimum beat: RD ack same cycle as strobe -> 2 cycles per word at zero wait states.
- Reset mid-transfer aborts immediately: no done pulse, registers cleared.

Decomposition:
- Shared package/include (alongside the arbiter's state defines):
  - DMA state encodings (3-bit)
  - register offsets REG_SRC=0, REG_DST=1, REG_CNT=2, REG_CTRL=3
  - CTRL bit positions START=0, DONE=1
- One natural sub-module, dma_regs: config register file, readback mux and done_sticky.
- FSM and datapath stay in dma_ctrl.

Test Plan:
- Reset: hold reset=0 with random inputs -> all outputs 0. Release, read CTRL -> 0x0000.
- Basic copy: SRC=0x0100, DST=0x0200, CNT=3, start; grant 1 cycle after breq; zero-wait ack -> words 0x0100..0x0102 appear at 0x0200..0x0202. One dma_done pulse. CNT reads 0, SRC=0x0103.
- Burst release: CNT=10, BURST=4 -> breq drops for exactly 1 cycle after beats 4 and 8. Transfer resumes only on re-grant. Total 10 beats.
- Grant loss: deassert dma_grant during a WR wait state -> that write completes. Next RD waits, breq stays 1. Re-grant resumes at the correct SRC.
- Edge cases: CNT=0 start -> dma_done next cycle, no bus_rd/bus_wr. SRC=0xFFFF, CNT=2 -> second read at 0x0000. Write SRC while busy -> ignored.
- Async reset mid-transfer at beat 2 -> breq/bus_rd/bus_wr fall without a clock edge, no dma_done.
